// File: rtl/rate_tick_controller_if.sv
// Control/status bundle between the board wrapper (master) and rate_tick_controller (slave).
// Carries run/pause/step/speed requests in and tick, wrap, clear and status out.
interface rate_tick_controller_if;
   logic       start;
   logic       stop;
   logic       step;
   logic [1:0] speed;
   logic       tick;
   logic       wrap;
   logic       count_clr;
   logic       busy;
   logic [1:0] state;
   logic [3:0] ticks;

   modport master (
      output start, stop, step, speed,
      input  tick, wrap, count_clr, busy, state, ticks
   );

   modport slave (
      input  start, stop, step, speed,
      output tick, wrap, count_clr, busy, state, ticks
   );
endinterface

// File: rtl/rate_tick_controller.sv
// Run/pause/step sequencer owning the reload divider that paces the display counter.
// Define FAST_SIM_EN to shrink the reloads to 3/7/15 for simulation; leave undefined for synthesis.
module rate_tick_controller #(
   parameter int CLK_HZ    = 50000000,
   parameter int CNT_W     = 29,
   parameter int MAX_COUNT = 15
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   rate_tick_controller_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_STEP  = 2'b11;

`ifdef FAST_SIM_EN
   localparam logic [CNT_W-1:0] L_R1 = CNT_W'(3);
   localparam logic [CNT_W-1:0] L_R2 = CNT_W'(7);
   localparam logic [CNT_W-1:0] L_R3 = CNT_W'(15);
`else
   // 64-bit intermediates so 4*CLK_HZ-1 never truncates before the final cast.
   localparam logic [CNT_W-1:0] L_R1 = CNT_W'(64'(CLK_HZ) - 64'd1);
   localparam logic [CNT_W-1:0] L_R2 = CNT_W'(64'(CLK_HZ) * 64'd2 - 64'd1);
   localparam logic [CNT_W-1:0] L_R3 = CNT_W'(64'(CLK_HZ) * 64'd4 - 64'd1);
`endif

   localparam logic [3:0] L_MAX = 4'(MAX_COUNT);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_div;
   logic             r_tick;
   logic             r_wrap;
   logic             r_count_clr;
   logic [3:0]       r_ticks;

   logic [CNT_W-1:0] w_reload;
   logic [1:0]       w_state_nxt;
   logic             w_cnt_en;
   logic             w_step_tick;
   logic             w_tick_nxt;
   logic [3:0]       w_ticks_inc;
   logic [3:0]       w_ticks_nxt;

   always_comb begin
      w_reload = '0;
      case (bus.speed)
         2'b00:   w_reload = '0;
         2'b01:   w_reload = L_R1;
         2'b10:   w_reload = L_R2;
         default: w_reload = L_R3;
      endcase
   end

   // The cycle that leaves IDLE/PAUSE on start already counts, so the first tick lands in RUN cycle R+1.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_en    = 1'b0;
      w_step_tick = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start && !bus.stop) begin
               w_state_nxt = S_RUN;
               w_cnt_en    = 1'b1;
            end
         end
         S_RUN: begin
            if (bus.stop) w_state_nxt = S_PAUSE;
            else          w_cnt_en    = 1'b1;
         end
         S_PAUSE: begin
            if (bus.stop) begin
               w_state_nxt = S_IDLE;
            end else if (bus.start) begin
               w_state_nxt = S_RUN;
               w_cnt_en    = 1'b1;
            end else if (bus.step) begin
               w_state_nxt = S_STEP;
               w_step_tick = 1'b1;
            end
         end
         default: w_state_nxt = bus.stop ? S_IDLE : S_PAUSE;
      endcase
   end

   always_comb begin
      w_tick_nxt  = (w_cnt_en && (r_div == '0)) || w_step_tick;
      w_ticks_inc = r_ticks;
      if (r_tick) w_ticks_inc = (r_ticks == L_MAX) ? 4'd0 : r_ticks + 4'd1;
      w_ticks_nxt = (w_state_nxt == S_IDLE) ? 4'd0 : w_ticks_inc;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_div       <= w_reload;
         r_tick      <= 1'b0;
         r_wrap      <= 1'b0;
         r_count_clr <= 1'b1;
         r_ticks     <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_tick      <= w_tick_nxt;
         r_wrap      <= w_tick_nxt && (w_ticks_nxt == L_MAX);
         r_count_clr <= (w_state_nxt == S_IDLE);
         r_ticks     <= w_ticks_nxt;
         if (w_cnt_en)               r_div <= (r_div == '0) ? w_reload : r_div - CNT_W'(1);
         else if (r_state == S_IDLE) r_div <= w_reload;
      end
   end

   assign bus.tick      = r_tick;
   assign bus.wrap      = r_wrap;
   assign bus.count_clr = r_count_clr;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.state     = r_state;
   assign bus.ticks     = r_ticks;

endmodule

// File: doc/rate_tick_controller.md
Name: rate_tick_controller

Overview:
- Sequencer for the rate-divider / 4-bit display counter datapath on the DE1-SoC.
- Owns the reload divider and issues one-cycle enable ticks to the downstream counter_8bit/hexdecoder chain.
- Provides run/pause/single-step/clear control and speed selection that is applied glitch-free at tick boundaries.
- Board wrapper drives it from KEY/SW; the counter consumes tick and count_clr.

Parameters:
- CLK_HZ, 50000000, input clock frequency; sets the 1 Hz base reload.
- CNT_W, 29, divider width; must hold 4*CLK_HZ-1.
- MAX_COUNT, 15, terminal value of the mirrored tick count; wrap fires at this value.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level-sampled: run / resume.
- stop  in  1  level-sampled: pause; a stop while paused clears to idle.
- step  in  1  single tick while paused.
- speed  in  2  rate select.
- tick  out  1  registered one-cycle enable to the counter.
- wrap  out  1  registered pulse coincident with the tick that takes ticks from MAX_COUNT to 0.
- count_clr  out  1  registered; high in IDLE and during reset.
- busy  out  1  state != IDLE.
- state  out  2  IDLE=00, RUN=01, PAUSE=10, STEP=11.
- ticks  out  4  mirror of the downstream count value.

Behaviour:
- Reload R(speed):
  - 00 -> 0 (tick every cycle)
  - 01 -> CLK_HZ-1
  - 10 -> 2*CLK_HZ-1
  - 11 -> 4*CLK_HZ-1
  - Computed at CNT_W bits; no truncation allowed.
- Reset:
  - state=IDLE, div=R(speed), tick=0, wrap=0, ticks=0, count_clr=1, busy=0.
- Input precedence per cycle: reset > stop > start > step.
- IDLE:
  - div continuously reloads R(speed); tick=0, count_clr=1, ticks held 0.
  - start -> RUN; count_clr=0 from the first RUN cycle.
  - stop and step are ignored.
- RUN:
  - Each cycle: if div==0, then tick<=1 next cycle and div<=R(speed sampled that cycle); else div<=div-1.
  - The first tick appears in RUN cycle R+1; period is R+1 cycles. For speed 00, tick stays high every cycle from RUN cycle 1.
  - A speed change mid-count affects only the next reload; the current count completes.
  - stop -> PAUSE with div frozen at its current value. If div==0 in that same cycle, no tick is issued and div stays 0.
  - start while in RUN is ignored.
- PAUSE:
  - div, ticks frozen; tick=0.
  - start -> RUN, resuming from the frozen div.
  - step -> STEP.
  - stop -> IDLE (count_clr=1 next cycle, ticks=0).
- STEP:
  - tick=1 for exactly one cycle; div unchanged; returns to PAUSE next cycle.
  - An input during STEP is evaluated in PAUSE next cycle, except stop, which forces IDLE after the tick.
- ticks:
  - Increments on every tick cycle; wraps MAX_COUNT -> 0.
  - wrap is high on the tick cycle where ticks==MAX_COUNT before the increment.
- Reset mid-RUN: next cycle is the full reset state; no partial tick.
- Outputs are registered; no combinational path from inputs to tick or wrap.

Optional Feature:
- Macro: FAST_SIM_EN.
- Defined: reloads become 00->0, 01->3, 10->7, 11->15, so benches finish quickly. All other behaviour is identical.
- Undefined: the CLK_HZ-based reloads above.
- Synthesis builds must leave it undefined.

Test Plan (FAST_SIM_EN defined):
1. Reset 2 cycles, speed=01, start pulse -> tick high in RUN cycles 4, 8, 12 (period 4); ticks 1, 2, 3; count_clr 1 -> 0 on RUN entry.
2. speed=00, start -> tick high every cycle from RUN cycle 1. After 16 ticks, ticks=0 and wrap high exactly on the 16th tick.
3. RUN at speed=10, stop at div=5 -> PAUSE, tick=0 for 20 cycles. start -> next tick 6 cycles later.
4. PAUSE, step pulse -> one tick, state 10->11->10, ticks +1, div unchanged. stop+start in the same cycle -> stop wins, state=IDLE, count_clr=1, ticks=0.
5. RUN at speed=01, switch to 11 at div=2 -> tick after 3 cycles, then period 16.
6. reset asserted during a RUN tick cycle -> next cycle tick=0, ticks=0, state=IDLE, busy=0.
